// File: rtl/cmplx_bfly_r2.sv
// cmplx_bfly_r2: pipelined radix-2 complex butterfly X = A + W'B, Y = A - W'B using three multipliers,
// with optional twiddle conjugation, /2 scaling, round-half-up, saturation and a sticky overflow flag.
module cmplx_bfly_r2 #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic                 inv,
    input  logic                 scale,
    input  logic signed [DW-1:0] a_r,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_r,
    input  logic signed [DW-1:0] b_i,
    input  logic signed [TW-1:0] w_r,
    input  logic signed [TW-1:0] w_i,
    input  logic                 ovf_clr,
    output logic                 out_valid,
    output logic signed [DW-1:0] x_r,
    output logic signed [DW-1:0] x_i,
    output logic signed [DW-1:0] y_r,
    output logic signed [DW-1:0] y_i,
    output logic                 ovf
);
    localparam int FW = DW + TW + 2;
    localparam logic signed [FW-1:0] ONE   = {{(FW-1){1'b0}}, 1'b1};
    localparam logic signed [FW-1:0] HALF0 = ONE <<< (TW-3);
    localparam logic signed [FW-1:0] HALF1 = ONE <<< (TW-2);
    localparam logic signed [FW-1:0] MAXV  = {{(FW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [FW-1:0] MINV  = ~MAXV;

    // Returns {saturated, value} after round-half-up and clamping to DW bits.
    function automatic logic [DW:0] rnd_sat(input logic signed [FW-1:0] f, input logic sc);
        logic signed [FW-1:0] t;
        logic hi, lo;
        t  = f + (sc ? HALF1 : HALF0);
        t  = sc ? (t >>> (TW-1)) : (t >>> (TW-2));
        hi = t > MAXV;
        lo = t < MINV;
        return {hi | lo, hi ? MAXV[DW-1:0] : lo ? MINV[DW-1:0] : t[DW-1:0]};
    endfunction

    logic signed [TW:0]   w_wi;
    logic signed [DW:0]   w_s1;
    logic signed [TW+1:0] w_s2, w_s3;
    logic signed [FW-1:0] w_pr, w_pi, w_ar, w_ai;
    logic [DW:0]          w_xr, w_xi, w_yr, w_yi;
    logic                 w_sat;

    logic                 r_v1, r_sc1, r_v2, r_sc2, r_ov, r_ovf;
    logic signed [DW-1:0] r_a1_r, r_a1_i, r_b_r, r_b_i, r_a2_r, r_a2_i;
    logic signed [TW-1:0] r_w_r;
    logic signed [DW:0]   r_s1;
    logic signed [TW+1:0] r_s2, r_s3;
    logic signed [FW-1:0] r_pr, r_pi;
    logic signed [DW-1:0] r_x_r, r_x_i, r_y_r, r_y_i;

    // Widened before negation so the most negative twiddle does not wrap.
    assign w_wi = inv ? -(TW+1)'(w_i) : (TW+1)'(w_i);
    assign w_s1 = (DW+1)'(b_r) + (DW+1)'(b_i);
    assign w_s2 = (TW+2)'(w_wi) - (TW+2)'(w_r);
    assign w_s3 = (TW+2)'(w_r) + (TW+2)'(w_wi);

    assign w_pr = FW'(r_w_r) * FW'(r_s1) - FW'(r_b_i) * FW'(r_s3);
    assign w_pi = FW'(r_w_r) * FW'(r_s1) + FW'(r_b_r) * FW'(r_s2);

    assign w_ar  = FW'(r_a2_r) <<< (TW-2);
    assign w_ai  = FW'(r_a2_i) <<< (TW-2);
    assign w_xr  = rnd_sat(w_ar + r_pr, r_sc2);
    assign w_xi  = rnd_sat(w_ai + r_pi, r_sc2);
    assign w_yr  = rnd_sat(w_ar - r_pr, r_sc2);
    assign w_yi  = rnd_sat(w_ai - r_pi, r_sc2);
    assign w_sat = w_xr[DW] | w_xi[DW] | w_yr[DW] | w_yi[DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_sc1  <= 1'b0;
            r_a1_r <= '0;
            r_a1_i <= '0;
            r_b_r  <= '0;
            r_b_i  <= '0;
            r_w_r  <= '0;
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
        end else if (en) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_sc1  <= scale;
                r_a1_r <= a_r;
                r_a1_i <= a_i;
                r_b_r  <= b_r;
                r_b_i  <= b_i;
                r_w_r  <= w_r;
                r_s1   <= w_s1;
                r_s2   <= w_s2;
                r_s3   <= w_s3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_sc2  <= 1'b0;
            r_a2_r <= '0;
            r_a2_i <= '0;
            r_pr   <= '0;
            r_pi   <= '0;
        end else if (en) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sc2  <= r_sc1;
                r_a2_r <= r_a1_r;
                r_a2_i <= r_a1_i;
                r_pr   <= w_pr;
                r_pi   <= w_pi;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ov  <= 1'b0;
            r_x_r <= '0;
            r_x_i <= '0;
            r_y_r <= '0;
            r_y_i <= '0;
        end else if (en) begin
            r_ov <= r_v2;
            if (r_v2) begin
                r_x_r <= w_xr[DW-1:0];
                r_x_i <= w_xi[DW-1:0];
                r_y_r <= w_yr[DW-1:0];
                r_y_i <= w_yi[DW-1:0];
            end
        end
    end

    // A saturating sample on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else if (en && r_v2 && w_sat)
            r_ovf <= 1'b1;
        else if (ovf_clr)
            r_ovf <= 1'b0;
    end

    assign out_valid = r_ov;
    assign x_r       = r_x_r;
    assign x_i       = r_x_i;
    assign y_r       = r_y_r;
    assign y_i       = r_y_i;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_cmplx_bfly_r2.sv
// tb_cmplx_bfly_r2: scoreboard bench for cmplx_bfly_r2; a direct complex-product model predicts every
// output, plus directed timing, stall, reset and overflow-flag scenarios.
module tb_cmplx_bfly_r2;
    localparam int DW = 16;
    localparam int TW = 16;

    typedef struct {
        int xr, xi, yr, yi;
        bit sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, en, in_valid, inv, scale, ovf_clr;
    logic signed [DW-1:0] a_r, a_i, b_r, b_i;
    logic signed [TW-1:0] w_r, w_i;
    logic out_valid, ovf;
    logic signed [DW-1:0] x_r, x_i, y_r, y_i;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t m_ex;
    logic m_en;
    bit   any_sat;

    cmplx_bfly_r2 #(.DW(DW), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .inv(inv), .scale(scale),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .w_r(w_r), .w_i(w_i), .ovf_clr(ovf_clr),
        .out_valid(out_valid), .x_r(x_r), .x_i(x_i), .y_r(y_r), .y_i(y_i), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic longint rnd(longint f, bit sc);
        int s = TW - 2 + int'(sc);
        return (f + (longint'(1) <<< (s - 1))) >>> s;
    endfunction

    function automatic int clamp(longint v, inout bit sat);
        longint mx = (longint'(1) <<< (DW - 1)) - 1;
        if (v > mx) begin sat = 1'b1; return int'(mx); end
        if (v < -mx - 1) begin sat = 1'b1; return int'(-mx - 1); end
        return int'(v);
    endfunction

    function automatic exp_t model(int ar, int ai, int br, int bi, int wr, int wi, bit iv, bit sc);
        exp_t e;
        longint wie, pr, pi, ash_r, ash_i;
        wie   = iv ? -longint'(wi) : longint'(wi);
        pr    = longint'(wr) * br - wie * bi;
        pi    = longint'(wr) * bi + wie * br;
        ash_r = longint'(ar) * (longint'(1) <<< (TW - 2));
        ash_i = longint'(ai) * (longint'(1) <<< (TW - 2));
        e.sat = 1'b0;
        e.xr  = clamp(rnd(ash_r + pr, sc), e.sat);
        e.xi  = clamp(rnd(ash_i + pi, sc), e.sat);
        e.yr  = clamp(rnd(ash_r - pr, sc), e.sat);
        e.yi  = clamp(rnd(ash_i - pi, sc), e.sat);
        return e;
    endfunction

    // Applies one sample in the current cycle; it enters the scoreboard only if it will be accepted.
    task automatic drive(int ar, int ai, int br, int bi, int wr, int wi, bit iv, bit sc);
        exp_t e;
        a_r = DW'(ar); a_i = DW'(ai); b_r = DW'(br); b_i = DW'(bi);
        w_r = TW'(wr); w_i = TW'(wi); inv = iv; scale = sc; in_valid = 1'b1;
        if (en) begin
            e = model(ar, ai, br, bi, wr, wi, iv, sc);
            sb.push_back(e);
            any_sat |= e.sat;
        end
    endtask

    task automatic send(int ar, int ai, int br, int bi, int wr, int wi, bit iv, bit sc);
        @(negedge clk);
        drive(ar, ai, br, bi, wr, wi, iv, sc);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results still pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    always @(posedge clk) begin
        m_en = en & rst_n;
        #1;
        if (m_en && rst_n && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: x=(%0d,%0d) y=(%0d,%0d) with no sample pending", x_r, x_i, y_r, y_i);
            end else begin
                m_ex = sb.pop_front();
                if ({x_r, x_i, y_r, y_i} !== {DW'(m_ex.xr), DW'(m_ex.xi), DW'(m_ex.yr), DW'(m_ex.yi)}) begin
                    errors++;
                    $display("FAIL scoreboard: x=(%0d,%0d) y=(%0d,%0d), required x=(%0d,%0d) y=(%0d,%0d)",
                             x_r, x_i, y_r, y_i, m_ex.xr, m_ex.xi, m_ex.yr, m_ex.yi);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; inv = 1'b0; scale = 1'b0; ovf_clr = 1'b0;
        a_r = '0; a_i = '0; b_r = '0; b_i = '0; w_r = '0; w_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, ovf, x_r, x_i, y_r, y_i} !== '0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b ovf=%b x=(%0d,%0d) y=(%0d,%0d), required all 0",
                     out_valid, ovf, x_r, x_i, y_r, y_i);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        send(1000, 0, 2000, 0, 16384, 0, 0, 0);
        idle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL identity_early: out_valid=%b after 2 edges, required 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, ovf, x_r, x_i, y_r, y_i} !== {1'b1, 1'b0, 16'sd3000, 16'sd0, -16'sd1000, 16'sd0}) begin
            errors++;
            $display("FAIL identity: out_valid=%b ovf=%b x=(%0d,%0d) y=(%0d,%0d), required 1 0 (3000,0) (-1000,0)",
                     out_valid, ovf, x_r, x_i, y_r, y_i);
        end
        drain("identity");
    endtask

    task automatic test_rotation();
        send(0, 0, 100, 200, 0, 16384, 0, 0);
        send(0, 0, 100, 200, 0, 16384, 1, 0);
        idle();
        @(negedge clk);
        checks++;
        if ({out_valid, x_r, x_i, y_r, y_i} !== {1'b1, -16'sd200, 16'sd100, 16'sd200, -16'sd100}) begin
            errors++;
            $display("FAIL rotation: out_valid=%b x=(%0d,%0d) y=(%0d,%0d), required 1 (-200,100) (200,-100)",
                     out_valid, x_r, x_i, y_r, y_i);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, x_r, x_i, y_r, y_i} !== {1'b1, 16'sd200, -16'sd100, -16'sd200, 16'sd100}) begin
            errors++;
            $display("FAIL conjugate: out_valid=%b x=(%0d,%0d) y=(%0d,%0d), required 1 (200,-100) (-200,100)",
                     out_valid, x_r, x_i, y_r, y_i);
        end
        drain("rotation");
    endtask

    task automatic test_rounding();
        send(0, 0, 1, 0, 8192, 0, 0, 0);
        send(0, 0, -1, 0, 8192, 0, 0, 0);
        idle();
        @(negedge clk);
        checks++;
        if ({x_r, y_r} !== {16'sd1, 16'sd0}) begin
            errors++;
            $display("FAIL round_pos: x_r=%0d y_r=%0d, required 1 0", x_r, y_r);
        end
        @(negedge clk);
        checks++;
        if ({x_r, y_r} !== {16'sd0, 16'sd1}) begin
            errors++;
            $display("FAIL round_neg: x_r=%0d y_r=%0d, required 0 1", x_r, y_r);
        end
        drain("rounding");
    endtask

    task automatic test_saturation();
        send(32767, 0, 32767, 0, 16384, 0, 0, 0);
        idle();
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, x_r, y_r, ovf} !== {1'b1, 16'sd32767, 16'sd0, 1'b1}) begin
            errors++;
            $display("FAIL saturate: out_valid=%b x_r=%0d y_r=%0d ovf=%b, required 1 32767 0 1", out_valid, x_r, y_r, ovf);
        end
        drain("saturate");
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, ovf} !== 2'b00) begin
            errors++;
            $display("FAIL sat_reset: out_valid=%b ovf=%b, required 0 0", out_valid, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(32767, 0, 32767, 0, 16384, 0, 0, 1);
        idle();
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, x_r, y_r, ovf} !== {1'b1, 16'sd32767, 16'sd0, 1'b0}) begin
            errors++;
            $display("FAIL scale: out_valid=%b x_r=%0d y_r=%0d ovf=%b, required 1 32767 0 0", out_valid, x_r, y_r, ovf);
        end
        drain("scale");
    endtask

    task automatic test_stall();
        exp_t e0, e3;
        e0 = model(1000, -500, 300, 40, 11585, 11585, 0, 0);
        e3 = model(-2500, 900, -70, 600, 11585, -11585, 1, 1);
        send(1000, -500, 300, 40, 11585, 11585, 0, 0);
        send(2000, 300, -150, 250, -16384, 5000, 0, 0);
        send(-300, 1200, 800, -900, 3000, -12000, 1, 0);
        @(negedge clk);
        en = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({out_valid, x_r, x_i, y_r, y_i} !== {1'b1, DW'(e0.xr), DW'(e0.xi), DW'(e0.yr), DW'(e0.yi)}) begin
                errors++;
                $display("FAIL stall_hold%0d: out_valid=%b x=(%0d,%0d) y=(%0d,%0d), required 1 (%0d,%0d) (%0d,%0d)",
                         i, out_valid, x_r, x_i, y_r, y_i, e0.xr, e0.xi, e0.yr, e0.yi);
            end
            if (i < 2) @(negedge clk);
        end
        en = 1'b1;
        drive(-2500, 900, -70, 600, 11585, -11585, 1, 1);
        idle();
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, x_r, x_i, y_r, y_i} !== {1'b1, DW'(e3.xr), DW'(e3.xi), DW'(e3.yr), DW'(e3.yi)}) begin
            errors++;
            $display("FAIL stall_last: out_valid=%b x=(%0d,%0d) y=(%0d,%0d), required 1 (%0d,%0d) (%0d,%0d)",
                     out_valid, x_r, x_i, y_r, y_i, e3.xr, e3.xi, e3.yr, e3.yi);
        end
        drain("stall");
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        send(4000, 100, 500, -500, 16384, 0, 0, 0);
        send(-4000, 200, 700, 300, 0, 16384, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0; in_valid = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({out_valid, ovf, x_r, x_i, y_r, y_i} !== '0) begin
            errors++;
            $display("FAIL midstream_reset: out_valid=%b ovf=%b x=(%0d,%0d) y=(%0d,%0d), required all 0",
                     out_valid, ovf, x_r, x_i, y_r, y_i);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL stale_after_reset: out_valid high for %0d cycles, required 0", seen);
        end
    endtask

    task automatic test_ovf_clr();
        send(-32768, 0, 32767, 0, 16384, 0, 0, 0);
        idle();
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pre: ovf=%b, required 0", ovf);
        end
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if ({out_valid, ovf} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_set_wins: out_valid=%b ovf=%b, required 1 1", out_valid, ovf);
        end
        @(negedge clk);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf=%b, required 1", ovf);
        end
        en = 1'b0; ovf_clr = 1'b1;
        @(negedge clk);
        en = 1'b1; ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b, required 0", ovf);
        end
        drain("ovf_clr");
    endtask

    task automatic test_back_to_back();
        any_sat = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0)
                drive($urandom_range(0, 40000) - 20000, $urandom_range(0, 40000) - 20000,
                      $urandom_range(0, 40000) - 20000, $urandom_range(0, 40000) - 20000,
                      $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                in_valid = 1'b0;
        end
        @(negedge clk);
        en = 1'b1; in_valid = 1'b0;
        drain("back_to_back");
        checks++;
        if (ovf !== any_sat) begin
            errors++;
            $display("FAIL random_ovf: ovf=%b, required %b", ovf, any_sat);
        end
    endtask

    initial begin
        any_sat = 1'b0;
        test_reset();
        test_identity();
        test_rotation();
        test_rounding();
        test_saturation();
        test_stall();
        test_reset_midstream();
        test_ovf_clr();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
